// File: rtl/neptuno_joy_pkg.sv
// Shared types and constants for the Neptuno DB9 joystick reader.
// Holds the FSM state encoding and the raw-pin / output-button bit positions.
package neptuno_joy_pkg;

    localparam int WORD_BITS = 16;
    localparam int HALF_BITS = $clog2(2 * WORD_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        LOAD,
        SHIFT,
        DONE,
        UPDATE
    } joy_state_e;

    // Raw byte from one DB9 port, pins active low
    localparam int RAW_U  = 7;
    localparam int RAW_D  = 6;
    localparam int RAW_L  = 5;
    localparam int RAW_R  = 4;
    localparam int RAW_P6 = 3;
    localparam int RAW_P9 = 2;

    // Active-high button word presented to the guest core
    localparam int OUT_R  = 0;
    localparam int OUT_L  = 1;
    localparam int OUT_D  = 2;
    localparam int OUT_U  = 3;
    localparam int OUT_B  = 4;
    localparam int OUT_C  = 5;
    localparam int OUT_A  = 6;
    localparam int OUT_ST = 7;

    // A Megadrive pad pulls both L and R low while select is low
    function automatic logic md_detect(input logic raw_l, input logic raw_r);
        return !raw_l && !raw_r;
    endfunction

endpackage

// File: rtl/neptuno_joy_reader_if.sv
// Pin bundle between the reader and the board's 74HC165 chain / DB9 select line.
interface neptuno_joy_reader_if;

    logic JOY_CLK;
    logic JOY_LOAD;
    logic JOY_DATA;
    logic JOY_SEL;

    modport master (output JOY_CLK, output JOY_LOAD, output JOY_SEL, input JOY_DATA);
    modport slave  (input JOY_CLK, input JOY_LOAD, input JOY_SEL, output JOY_DATA);

endinterface

// File: rtl/neptuno_joy_shift165.sv
// Tick-driven 74HC165 engine: one LOAD tick, then 16 bits at two ticks per bit,
// sampling the synchronised chain output MSB-first while JOY_CLK is low.
module neptuno_joy_shift165
    import neptuno_joy_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_i,
    input  logic                 start_i,
    input  logic                 data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WORD_BITS-1:0] word_o,
    output logic                 joy_clk_o,
    output logic                 joy_load_o
);

    localparam logic [HALF_BITS-1:0] HALF_LAST = HALF_BITS'(2 * WORD_BITS - 1);

    logic                 data_s1_q;
    logic                 data_s2_q;
    logic                 busy_q;
    logic                 load_n_q;
    logic                 jclk_q;
    logic [HALF_BITS-1:0] half_q;
    logic [WORD_BITS-1:0] sr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            data_s1_q <= data_i;
            data_s2_q <= data_s1_q;
        end
    end

    // NOTE: the data-path shift register is reset as well, so the word is never X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            load_n_q <= 1'b1;
            jclk_q   <= 1'b0;
            half_q   <= '0;
            sr_q     <= '0;
        end else if (tick_i) begin
            if (!busy_q) begin
                if (start_i) begin
                    busy_q   <= 1'b1;
                    load_n_q <= 1'b0;
                end
            end else if (!load_n_q) begin
                load_n_q <= 1'b1;
                half_q   <= '0;
            end else if (!half_q[0]) begin
                sr_q   <= {sr_q[WORD_BITS-2:0], data_s2_q};
                jclk_q <= 1'b1;
                half_q <= half_q + HALF_BITS'(1);
            end else begin
                jclk_q <= 1'b0;
                if (half_q == HALF_LAST) begin
                    busy_q <= 1'b0;
                end else begin
                    half_q <= half_q + HALF_BITS'(1);
                end
            end
        end
    end

    assign done_o     = tick_i && busy_q && load_n_q && (half_q == HALF_LAST);
    assign busy_o     = busy_q;
    assign word_o     = sr_q;
    assign joy_clk_o  = jclk_q;
    assign joy_load_o = load_n_q;

endmodule

// File: rtl/neptuno_joy_reader.sv
// Neptuno2 DB9 joystick reader: two select phases per frame through the 74HC165
// chain, Megadrive detection, and frame-latched active-high button words.
module neptuno_joy_reader
    import neptuno_joy_pkg::*;
#(
    parameter int CLK_DIV      = 8,
    parameter int SETTLE_TICKS = 4,
    parameter int IDLE_TICKS   = 256
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    neptuno_joy_reader_if.master joy_bus,
    output logic [7:0]           joy1,
    output logic [7:0]           joy2,
    output logic                 md1,
    output logic                 md2,
    output logic                 joy_strobe
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (IDLE_TICKS > SETTLE_TICKS) ? IDLE_TICKS : SETTLE_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

    joy_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             sel_q, sel_d;
    logic [1:0][7:0]  w_hi_q, w_hi_d;
    logic [1:0][7:0]  w_lo_q, w_lo_d;
    logic [7:0]       joy1_q, joy1_d, joy2_q, joy2_d;
    logic             md1_q, md1_d, md2_q, md2_d;
    logic             strobe_q, strobe_d;

    logic                 tick;
    logic                 eng_start, eng_busy, eng_done;
    logic [WORD_BITS-1:0] eng_word;
    logic [1:0][7:0]      map_joy;
    logic [1:0]           map_md;
    logic                 unused_raw;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) div_q <= '0;
        else          div_q <= tick ? '0 : div_q + DIV_W'(1);
    end
    assign tick = (div_q == DIV_LAST);

    neptuno_joy_shift165 u_shift (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .tick_i    (tick),
        .start_i   (eng_start),
        .data_i    (joy_bus.JOY_DATA),
        .busy_o    (eng_busy),
        .done_o    (eng_done),
        .word_o    (eng_word),
        .joy_clk_o (joy_bus.JOY_CLK),
        .joy_load_o(joy_bus.JOY_LOAD)
    );

    // Index 1 is port 1 (word[15:8]); directions and B/C always come from the select-high word
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        map_joy = '0;
        map_md  = '0;
        for (int p = 0; p < 2; p++) begin
            map_md[p]          = md_detect(w_lo_q[p][RAW_L], w_lo_q[p][RAW_R]);
            map_joy[p][OUT_U]  = ~w_hi_q[p][RAW_U];
            map_joy[p][OUT_D]  = ~w_hi_q[p][RAW_D];
            map_joy[p][OUT_L]  = ~w_hi_q[p][RAW_L];
            map_joy[p][OUT_R]  = ~w_hi_q[p][RAW_R];
            map_joy[p][OUT_B]  = ~w_hi_q[p][RAW_P6];
            map_joy[p][OUT_C]  = ~w_hi_q[p][RAW_P9];
            map_joy[p][OUT_A]  = map_md[p] & ~w_lo_q[p][RAW_P6];
            map_joy[p][OUT_ST] = map_md[p] & ~w_lo_q[p][RAW_P9];
        end
    end
    assign unused_raw = ^{w_hi_q, w_lo_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        sel_d     = sel_q;
        w_hi_d    = w_hi_q;
        w_lo_d    = w_lo_q;
        joy1_d    = joy1_q;
        joy2_d    = joy2_q;
        md1_d     = md1_q;
        md2_d     = md2_q;
        strobe_d  = 1'b0;
        eng_start = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (cnt_q == IDLE_LAST) begin
                        cnt_d   = '0;
                        sel_d   = 1'b1;
                        state_d = SEL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SEL: begin
                    if (cnt_q == SETTLE_LAST) begin
                        if (!eng_busy) begin
                            cnt_d     = '0;
                            eng_start = 1'b1;
                            state_d   = LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LOAD:  state_d = SHIFT;
                SHIFT: if (eng_done) state_d = DONE;
                DONE: begin
                    if (!phase_q) begin
                        w_hi_d  = eng_word;
                        phase_d = 1'b1;
                        sel_d   = 1'b0;
                        state_d = SEL;
                    end else begin
                        w_lo_d  = eng_word;
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    joy1_d   = map_joy[1];
                    joy2_d   = map_joy[0];
                    md1_d    = map_md[1];
                    md2_d    = map_md[0];
                    strobe_d = 1'b1;
                    phase_d  = 1'b0;
                    sel_d    = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            sel_q    <= 1'b1;
            w_hi_q   <= '1;
            w_lo_q   <= '1;
            joy1_q   <= '0;
            joy2_q   <= '0;
            md1_q    <= 1'b0;
            md2_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sel_q    <= sel_d;
            w_hi_q   <= w_hi_d;
            w_lo_q   <= w_lo_d;
            joy1_q   <= joy1_d;
            joy2_q   <= joy2_d;
            md1_q    <= md1_d;
            md2_q    <= md2_d;
            strobe_q <= strobe_d;
        end
    end

    assign joy_bus.JOY_SEL = sel_q;
    assign joy1            = joy1_q;
    assign joy2            = joy2_q;
    assign md1             = md1_q;
    assign md2             = md2_q;
    assign joy_strobe      = strobe_q;

endmodule

// File: tb/tb_neptuno_joy_reader.sv
// Scoreboard bench for neptuno_joy_reader: a 74HC165 chain model serves pad patterns,
// expected words are queued per frame and checked whenever joy_strobe fires.
module tb_neptuno_joy_reader;

    localparam int CLK_DIV      = 8;
    localparam int SETTLE_TICKS = 4;
    localparam int IDLE_TICKS   = 256;
    localparam int FRAME_CYC    = (IDLE_TICKS + 2 * (SETTLE_TICKS + 1 + 32 + 1) + 1) * CLK_DIV;

    typedef struct packed {
        logic [7:0] j1;
        logic [7:0] j2;
        logic       m1;
        logic       m2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] joy1, joy2;
    logic       md1, md2, joy_strobe;
    logic [15:0] pad_hi, pad_lo, chain;
    logic        prev_jclk;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   strobes  = 0;

    always #5 clk = ~clk;

    neptuno_joy_reader_if bus ();

    neptuno_joy_reader #(
        .CLK_DIV     (CLK_DIV),
        .SETTLE_TICKS(SETTLE_TICKS),
        .IDLE_TICKS  (IDLE_TICKS)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .joy_bus   (bus),
        .joy1      (joy1),
        .joy2      (joy2),
        .md1       (md1),
        .md2       (md2),
        .joy_strobe(joy_strobe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 74HC165 chain: parallel load while JOY_LOAD low, shift on JOY_CLK rising, QH = bit 15
    assign bus.JOY_DATA = chain[15];
    initial begin
        chain     = '1;
        prev_jclk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.JOY_LOAD === 1'b0)
                chain = (bus.JOY_SEL === 1'b1) ? pad_hi : pad_lo;
            else if (bus.JOY_CLK === 1'b1 && !prev_jclk)
                chain = {chain[14:0], 1'b1};
            prev_jclk = bus.JOY_CLK;
        end
    end

    // Scoreboard monitor: pop and compare on every strobe, and check frame spacing
    initial begin
        int   last_strobe;
        exp_t e;
        last_strobe = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) last_strobe = -1;
            if (joy_strobe === 1'b1) begin
                strobes++;
                check("strobe_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("joy1", joy1, e.j1);
                    check("joy2", joy2, e.j2);
                    check("md1", md1, e.m1);
                    check("md2", md2, e.m2);
                end
                if (last_strobe >= 0) check("frame_len", cyc - last_strobe, FRAME_CYC);
                last_strobe = cyc;
            end
        end
    end

    // Waveform monitor: LOAD width, JOY_CLK pulse width/count, select settle time
    initial begin
        int   load_lo, clk_hi, pulses, sel_stable;
        logic p_load, p_jclk, p_sel;
        bit   armed;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                load_lo = 0; clk_hi = 0; pulses = 0; sel_stable = 0;
                p_load = 1'b1; p_jclk = 1'b0; p_sel = 1'b1; armed = 0;
            end else begin
                if (bus.JOY_SEL === p_sel) sel_stable++;
                else                       sel_stable = 0;
                if (bus.JOY_LOAD === 1'b0 && p_load) begin
                    check("sel_settle", (sel_stable >= SETTLE_TICKS * CLK_DIV) ? SETTLE_TICKS * CLK_DIV : sel_stable,
                          SETTLE_TICKS * CLK_DIV);
                    if (armed) check("pulses_per_phase", pulses, 16);
                    pulses = 0;
                    armed  = 1;
                end
                if (bus.JOY_LOAD === 1'b0) load_lo++;
                if (bus.JOY_LOAD === 1'b1 && !p_load) begin
                    check("load_low_cycles", load_lo, CLK_DIV);
                    load_lo = 0;
                end
                if (bus.JOY_CLK === 1'b1) clk_hi++;
                if (bus.JOY_CLK === 1'b0 && p_jclk) begin
                    check("jclk_high_cycles", clk_hi, CLK_DIV);
                    clk_hi = 0;
                    pulses++;
                end
                if (joy_strobe === 1'b1 && armed) check("pulses_phase1", pulses, 16);
                p_load = bus.JOY_LOAD;
                p_jclk = bus.JOY_CLK;
                p_sel  = bus.JOY_SEL;
            end
        end
    end

    task automatic wait_strobe(input string name);
        int n;
        bit got;
        n   = 0;
        got = 0;
        while (n < 2 * FRAME_CYC && !got) begin
            @(negedge clk);
            n++;
            if (joy_strobe === 1'b1) got = 1;
        end
        check({name, "_strobe_seen"}, got, 1);
    endtask

    // Change pads mid-IDLE, confirm outputs hold, then wait for the frame that picks them up
    task automatic next_frame(input string name, input logic [15:0] hi, input logic [15:0] lo,
                              input exp_t e, input exp_t prev);
        repeat (50) @(negedge clk);
        pad_hi = hi;
        pad_lo = lo;
        sb.push_back(e);
        repeat (20) @(negedge clk);
        check({name, "_hold_joy1"}, joy1, prev.j1);
        check({name, "_hold_joy2"}, joy2, prev.j2);
        check({name, "_hold_md"}, {md1, md2}, {prev.m1, prev.m2});
        check({name, "_idle_sel"}, bus.JOY_SEL, 1);
        wait_strobe(name);
    endtask

    initial begin
        exp_t e_idle, e_atari, e_md2, e_mix, e_edge, e_post;
        int   n, rises, s0;
        logic pj;
        e_idle  = '{j1: 8'h00, j2: 8'h00, m1: 1'b0, m2: 1'b0};
        e_atari = '{j1: 8'h18, j2: 8'h00, m1: 1'b0, m2: 1'b0};
        e_md2   = '{j1: 8'h00, j2: 8'h60, m1: 1'b0, m2: 1'b1};
        e_mix   = '{j1: 8'hC8, j2: 8'h25, m1: 1'b1, m2: 1'b0};
        e_edge  = '{j1: 8'h00, j2: 8'hFF, m1: 1'b0, m2: 1'b1};
        e_post  = '{j1: 8'h00, j2: 8'h08, m1: 1'b1, m2: 1'b0};

        pad_hi = '1;
        pad_lo = '1;
        rst_n  = 1'b1;
        #3 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_jclk", bus.JOY_CLK, 0);
        check("rst_load", bus.JOY_LOAD, 1);
        check("rst_sel", bus.JOY_SEL, 1);
        check("rst_joy", {joy1, joy2}, 16'h0000);
        check("rst_md_strobe", {md1, md2, joy_strobe}, 3'b000);

        sb.push_back(e_idle);
        #2 rst_n = 1'b1;
        wait_strobe("idle_chain");
        check("sel_after_frame", bus.JOY_SEL, 1);

        next_frame("atari_p1", 16'h77FF, 16'h77FF, e_atari, e_idle);
        next_frame("md_p2", 16'hFFFB, 16'hFFC7, e_md2, e_atari);
        next_frame("mix", 16'h7FAB, 16'hC3AB, e_mix, e_md2);
        next_frame("edge", 16'hFF03, 16'hD703, e_edge, e_mix);

        // Abort a frame during the select-low shift; no strobe may follow
        repeat (50) @(negedge clk);
        n = 0;
        while (n < FRAME_CYC && bus.JOY_SEL !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        check("reach_phase1", bus.JOY_SEL, 0);
        n = 0;
        rises = 0;
        pj = bus.JOY_CLK;
        while (n < 40 * CLK_DIV && rises < 5) begin
            @(negedge clk);
            n++;
            if (bus.JOY_CLK === 1'b1 && pj !== 1'b1) rises++;
            pj = bus.JOY_CLK;
        end
        check("phase1_shifting", rises, 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_jclk", bus.JOY_CLK, 0);
        check("abort_load", bus.JOY_LOAD, 1);
        check("abort_sel", bus.JOY_SEL, 1);
        check("abort_joy", {joy1, joy2}, 16'h0000);
        check("abort_md_strobe", {md1, md2, joy_strobe}, 3'b000);
        s0 = strobes;
        repeat (20) @(negedge clk);
        check("no_strobe_in_reset", strobes, s0);

        pad_hi = 16'hFF7F;
        pad_lo = 16'hCF7F;
        sb.push_back(e_post);
        #2 rst_n = 1'b1;
        wait_strobe("post_reset");
        next_frame("post_repeat", 16'hFF7F, 16'hCF7F, e_post, e_post);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
